// File: rtl/uart_receiver_param_if.sv
// Pad-side / consumer-side signal bundle for the parametrised UART receiver.
// The receiver attaches as slave; the line driver and byte consumer use master.
`timescale 1ns/1ps
interface uart_receiver_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 i_RX;
    logic [DATA_BITS-1:0] o_DATA;
    logic                 o_RX_DONE;
    logic                 o_PARITY_ERR;
    logic                 o_FRAME_ERR;
    logic                 o_BUSY;

    modport master (
        output i_RX,
        input  o_DATA, o_RX_DONE, o_PARITY_ERR, o_FRAME_ERR, o_BUSY
    );

    modport slave (
        input  i_RX,
        output o_DATA, o_RX_DONE, o_PARITY_ERR, o_FRAME_ERR, o_BUSY
    );
endinterface

// File: rtl/uart_receiver_param.sv
// Oversampling UART receiver: 2-flop synchroniser, mid-bit sampling, false-start
// rejection, optional parity, 1 or 2 checked stop bits, break lockout after a framing error.
`timescale 1ns/1ps
module uart_receiver_param #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input logic                  i_CLK,
    input logic                  i_RST,
    uart_receiver_param_if.slave bus
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                 sync1, rx_s;
    logic [2:0]           state, state_n;
    logic [CW-1:0]        clk_cnt, clk_cnt_n;
    logic [BW-1:0]        bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par_acc, par_acc_n;
    logic                 par_bad, par_bad_n;
    logic                 ferr_acc, ferr_acc_n;
    logic                 stop_bad;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 done_q, done_n;
    logic                 perr_q, perr_n;
    logic                 ferr_q, ferr_n;
    logic                 busy_q, busy_n;

    // Line synchroniser; resets to idle-high so reset never looks like a start bit.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= bus.i_RX;
            rx_s  <= sync1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state    <= S_IDLE;
            clk_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            ferr_acc <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            par_acc  <= par_acc_n;
            par_bad  <= par_bad_n;
            ferr_acc <= ferr_acc_n;
            data_q   <= data_n;
            done_q   <= done_n;
            perr_q   <= perr_n;
            ferr_q   <= ferr_n;
            busy_q   <= busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n    = state;
        clk_cnt_n  = clk_cnt + CW'(1);
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        par_acc_n  = par_acc;
        par_bad_n  = par_bad;
        ferr_acc_n = ferr_acc;
        data_n     = data_q;
        done_n     = 1'b0;
        perr_n     = perr_q;
        ferr_n     = ferr_q;
        stop_bad   = ferr_acc | ~rx_s;

        case (state)
            S_IDLE: begin
                clk_cnt_n = '0;
                if (!rx_s) begin
                    state_n    = S_START;
                    bit_cnt_n  = '0;
                    par_acc_n  = 1'b0;
                    par_bad_n  = 1'b0;
                    ferr_acc_n = 1'b0;
                end
            end
            S_START: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    shift_n   = {rx_s, shift[DATA_BITS-1:1]};
                    par_acc_n = par_acc ^ rx_s;
                    if (bit_cnt == LAST_DATA) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                    par_bad_n = par_acc ^ rx_s ^ (PARITY_ODD != 0);
                    state_n   = S_STOP;
                end
            end
            S_STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_n  = '0;
                    ferr_acc_n = stop_bad;
                    if (bit_cnt == LAST_STOP) begin
                        // Publish the frame on the cycle after the last stop sample.
                        bit_cnt_n = '0;
                        data_n    = shift;
                        done_n    = 1'b1;
                        perr_n    = par_bad;
                        ferr_n    = stop_bad;
                        state_n   = stop_bad ? S_BREAK : S_IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt + BW'(1);
                    end
                end
            end
            S_BREAK: begin
                clk_cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: begin
                clk_cnt_n = '0;
                state_n   = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    assign bus.o_DATA       = data_q;
    assign bus.o_RX_DONE    = done_q;
    assign bus.o_PARITY_ERR = perr_q;
    assign bus.o_FRAME_ERR  = ferr_q;
    assign bus.o_BUSY       = busy_q;
endmodule

// File: tb/tb_uart_receiver_param.sv
// Directed bench: four receiver configurations share one serial line driver;
// sel routes the line to one DUT while the others see idle-high.
`timescale 1ns/1ps
module tb_uart_receiver_param;
    localparam int CPB = 16;

    logic clk, rst, rst5, rst_d5, line;
    int   sel;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   lat_def = 0;
    int   n_def = 0, n_par = 0, n_stp = 0, n_d5 = 0;

    uart_receiver_param_if #(.DATA_BITS(8)) if_def ();
    uart_receiver_param_if #(.DATA_BITS(8)) if_par ();
    uart_receiver_param_if #(.DATA_BITS(8)) if_stp ();
    uart_receiver_param_if #(.DATA_BITS(5)) if_d5 ();

    assign if_def.i_RX = (sel == 0) ? line : 1'b1;
    assign if_par.i_RX = (sel == 1) ? line : 1'b1;
    assign if_stp.i_RX = (sel == 2) ? line : 1'b1;
    assign if_d5.i_RX  = (sel == 3) ? line : 1'b1;
    assign rst_d5      = rst | rst5;

    uart_receiver_param #(.CLKS_PER_BIT(CPB)) u_def (.i_CLK(clk), .i_RST(rst), .bus(if_def));
    uart_receiver_param #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0))
        u_par (.i_CLK(clk), .i_RST(rst), .bus(if_par));
    uart_receiver_param #(.CLKS_PER_BIT(CPB), .STOP_BITS(2))
        u_stp (.i_CLK(clk), .i_RST(rst), .bus(if_stp));
    uart_receiver_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5))
        u_d5 (.i_CLK(clk), .i_RST(rst_d5), .bus(if_d5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses per DUT and timestamp the default DUT's pulse.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (if_def.o_RX_DONE) begin
            n_def   <= n_def + 1;
            lat_def <= cyc - t0;
        end
        if (if_par.o_RX_DONE) n_par <= n_par + 1;
        if (if_stp.o_RX_DONE) n_stp <= n_stp + 1;
        if (if_d5.o_RX_DONE)  n_d5  <= n_d5 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive n bits LSB first, one bit period each.
    task automatic send(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            line = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        line = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst5 = 1'b0; line = 1'b1; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  32'(if_def.o_DATA), 32'h0);
        check("rst_done",  32'(if_def.o_RX_DONE), 32'h0);
        check("rst_perr",  32'(if_def.o_PARITY_ERR), 32'h0);
        check("rst_ferr",  32'(if_def.o_FRAME_ERR), 32'h0);
        check("rst_busy",  32'(if_def.o_BUSY), 32'h0);
        rst = 1'b0;
        idle(4);
        check("post_rst_ndone", 32'(n_def), 32'd0);

        // Frame 0xA5 on default DUT, latency 155 cycles expected.
        sel = 0;
        t0 = cyc;
        send(16'({1'b1, 8'hA5, 1'b0}), 10);
        idle(4);
        check("a5_ndone", 32'(n_def), 32'd1);
        check("a5_data",  32'(if_def.o_DATA), 32'hA5);
        check("a5_perr",  32'(if_def.o_PARITY_ERR), 32'h0);
        check("a5_ferr",  32'(if_def.o_FRAME_ERR), 32'h0);
        check("a5_busy",  32'(if_def.o_BUSY), 32'h0);
        check("a5_latency_in_152_156", 32'(lat_def >= 152 && lat_def <= 156), 32'd1);

        // Back-to-back 0x00 then 0xFF.
        send(16'({1'b1, 8'h00, 1'b0}), 10);
        check("b2b0_ndone", 32'(n_def), 32'd2);
        check("b2b0_data",  32'(if_def.o_DATA), 32'h00);
        send(16'({1'b1, 8'hFF, 1'b0}), 10);
        idle(4);
        check("b2b1_ndone", 32'(n_def), 32'd3);
        check("b2b1_data",  32'(if_def.o_DATA), 32'hFF);
        check("b2b1_ferr",  32'(if_def.o_FRAME_ERR), 32'h0);

        // 5-cycle glitch is rejected at mid start bit.
        line = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("glitch_busy_hi", 32'(if_def.o_BUSY), 32'h1);
        idle(40);
        check("glitch_ndone", 32'(n_def), 32'd3);
        check("glitch_data",  32'(if_def.o_DATA), 32'hFF);
        check("glitch_busy",  32'(if_def.o_BUSY), 32'h0);

        // Even parity, 0x03: parity bit 0 is correct, 1 is an error.
        sel = 1;
        send(16'({1'b1, 1'b0, 8'h03, 1'b0}), 11);
        idle(4);
        check("par0_ndone", 32'(n_par), 32'd1);
        check("par0_data",  32'(if_par.o_DATA), 32'h03);
        check("par0_perr",  32'(if_par.o_PARITY_ERR), 32'h0);
        send(16'({1'b1, 1'b1, 8'h03, 1'b0}), 11);
        idle(4);
        check("par1_ndone", 32'(n_par), 32'd2);
        check("par1_data",  32'(if_par.o_DATA), 32'h03);
        check("par1_perr",  32'(if_par.o_PARITY_ERR), 32'h1);
        check("par1_ferr",  32'(if_par.o_FRAME_ERR), 32'h0);

        // Two stop bits, second low, then line held low 100 cycles.
        sel = 2;
        send(16'({1'b0, 1'b1, 8'h81, 1'b0}), 11);
        line = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("brk_ndone", 32'(n_stp), 32'd1);
        check("brk_ferr",  32'(if_stp.o_FRAME_ERR), 32'h1);
        check("brk_data",  32'(if_stp.o_DATA), 32'h81);
        check("brk_busy",  32'(if_stp.o_BUSY), 32'h1);
        idle(20);
        check("brk_rel_busy",  32'(if_stp.o_BUSY), 32'h0);
        check("brk_rel_ndone", 32'(n_stp), 32'd1);
        send(16'({2'b11, 8'h3C, 1'b0}), 11);
        idle(4);
        check("stp_ndone", 32'(n_stp), 32'd2);
        check("stp_data",  32'(if_stp.o_DATA), 32'h3C);
        check("stp_ferr",  32'(if_stp.o_FRAME_ERR), 32'h0);

        // 5-bit words: clean 0x11, aborted 0x15, clean 0x0A.
        sel = 3;
        send(16'({1'b1, 5'h11, 1'b0}), 7);
        idle(4);
        check("d5a_ndone", 32'(n_d5), 32'd1);
        check("d5a_data",  32'(if_d5.o_DATA), 32'h11);
        send(16'(3'b010), 3);
        line = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("d5_midframe_busy", 32'(if_d5.o_BUSY), 32'h1);
        rst5 = 1'b1;
        #1;
        check("d5rst_data", 32'(if_d5.o_DATA), 32'h0);
        check("d5rst_done", 32'(if_d5.o_RX_DONE), 32'h0);
        check("d5rst_perr", 32'(if_d5.o_PARITY_ERR), 32'h0);
        check("d5rst_ferr", 32'(if_d5.o_FRAME_ERR), 32'h0);
        check("d5rst_busy", 32'(if_d5.o_BUSY), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst5 = 1'b0;
        idle(40);
        check("d5abort_ndone", 32'(n_d5), 32'd1);
        check("d5abort_busy",  32'(if_d5.o_BUSY), 32'h0);
        send(16'({1'b1, 5'h0A, 1'b0}), 7);
        idle(4);
        check("d5b_ndone", 32'(n_d5), 32'd2);
        check("d5b_data",  32'(if_d5.o_DATA), 32'h0A);
        check("d5b_ferr",  32'(if_d5.o_FRAME_ERR), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_receiver_param.md
Name: uart_receiver_param

Overview:
Parametrised, oversampling UART receiver. It is the successor to the fixed 8-bit, one-clock-per-bit receiver. It adds:
- a configurable baud divider, data width, parity and stop-bit count;
- a metastability synchroniser;
- false-start rejection and mid-bit sampling;
- parity and framing error reporting.

It sits between the raw RX pad and the byte-stream consumer in the UART interface.

Parameters:
CLKS_PER_BIT, 16, i_CLK cycles per bit period; legal range >=4.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits checked; legal values 1 or 2.

Ports:
i_CLK  input  1  system clock; all logic on rising edge
i_RST  input  1  reset, asynchronous, active-high
i_RX  input  1  serial line, idle high, asynchronous to i_CLK
o_DATA  output  DATA_BITS  last received word; held until the next o_RX_DONE
o_RX_DONE  output  1  one-cycle pulse when a frame completes
o_PARITY_ERR  output  1  parity mismatch for the word in o_DATA; updated with o_RX_DONE
o_FRAME_ERR  output  1  a stop bit sampled low for the word in o_DATA; updated with o_RX_DONE
o_BUSY  output  1  high in every state except IDLE

Behaviour:
- Reset (async): state=IDLE, both synchroniser flops=1, counters=0, shift register=0, o_DATA=0, o_RX_DONE=0, o_PARITY_ERR=0, o_FRAME_ERR=0, o_BUSY=0. Reset mid-frame aborts the frame with no o_RX_DONE.
- Synchroniser: 2-flop chain on i_RX; the FSM sees only the synchronised value (rx_s). This adds 2 cycles of latency.
- Clock counter: width $clog2(CLKS_PER_BIT), cleared on every state change.
- Bit counter: width $clog2(DATA_BITS+1).
- States:
  - IDLE: rx_s=0 -> START.
  - START: at count CLKS_PER_BIT/2-1, sample rx_s. If 0 -> DATA. If 1 (glitch) -> IDLE; no outputs change.
  - DATA: at count CLKS_PER_BIT-1, sample rx_s into the shift register, LSB first (shift right, new bit enters at MSB). Increment the bit counter. After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
  - PARITY: at count CLKS_PER_BIT-1, sample the parity bit.
    - Even: error if XOR(data, parity bit)=1.
    - Odd: error if XOR(data, parity bit)=0.
  - STOP: at count CLKS_PER_BIT-1, sample each of the STOP_BITS stop bits. Any sample of 0 latches a frame error.
    - After the final stop sample, in the next cycle: o_DATA<=shift register, o_PARITY_ERR and o_FRAME_ERR updated, o_RX_DONE=1 for exactly one cycle.
    - Then -> IDLE if no frame error, else -> BREAK.
  - BREAK: wait until rx_s=1, then -> IDLE. This prevents a held-low line or break condition from being taken as new start bits.
- o_RX_DONE pulses even on a parity or framing error; the consumer qualifies the word with the error flags.
- Back-to-back frames: the FSM leaves STOP at mid-stop-bit, so a start bit directly after the stop bit is detected without loss.
- Total frame latency: i_RX falling edge to o_RX_DONE is 2 + CLKS_PER_BIT/2 + (DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, +-2.
- With PARITY_EN=0, o_PARITY_ERR stays 0.

Test Plan:
1. Default parameters, frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> o_DATA=0xA5, one o_RX_DONE pulse 154+-2 cycles after the start edge, both error flags 0, o_BUSY low afterwards.
2. Two back-to-back frames 0x00 then 0xFF, no idle gap -> two o_RX_DONE pulses with o_DATA=0x00 then 0xFF, no errors.
3. Low pulse of 5 cycles on idle line (CLKS_PER_BIT=16) -> FSM returns to IDLE, no o_RX_DONE, o_DATA unchanged.
4. PARITY_EN=1, PARITY_ODD=0, frame 0x03:
   - with parity bit 0 -> o_PARITY_ERR=0;
   - same frame with parity bit 1 -> o_PARITY_ERR=1, o_DATA=0x03.
5. STOP_BITS=2, second stop bit driven 0, then line held low 100 cycles, then high, then frame 0x3C -> first o_RX_DONE with o_FRAME_ERR=1; no spurious frame during the low period; then o_DATA=0x3C with o_FRAME_ERR=0.
6. DATA_BITS=5, frame 0x15 with i_RST pulsed high during the third data bit, then a clean 0x0A frame -> all outputs 0 immediately on reset, no done for the aborted frame, then o_DATA=0x0A.
